// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Starts on a one-cycle start pulse, runs WIDTH iterations, then pulses done
// for one cycle with the product held on product.
module alu_iter_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;

  // One shift-add step per busy cycle; done is raised after the last step.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_W'(WIDTH - 1);
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Engine state register; reset discards any product in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: single-cycle ops with registered result, an
// iterative multiplier, illegal-op flag and output backpressure.
// Build option ALU_DIV_EN adds a signed restoring divider (op 1010).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] alu_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_result,
  output logic              zero,
  output logic              illegal
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_illegal;
  logic               is_mul;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;

  assign in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHAMT_W-1:0];

`ifdef ALU_DIV_EN
  logic               is_div;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               div_neg_q, div_neg_d;
  logic [SHAMT_W:0]   div_cnt_q, div_cnt_d;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   div_quot;
`endif

  // Decode the op and compute every single-cycle result.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    is_mul     = 1'b0;
`ifdef ALU_DIV_EN
    is_div     = 1'b0;
`endif
    case (alu_control)
      CTRL_W'(ALU_AND): sc_result = a & b;
      CTRL_W'(ALU_OR):  sc_result = a | b;
      CTRL_W'(ALU_ADD): sc_result = a + b;
      CTRL_W'(ALU_XOR): sc_result = a ^ b;
      CTRL_W'(ALU_SLL): sc_result = a << shamt;
      CTRL_W'(ALU_SRL): sc_result = a >> shamt;
      CTRL_W'(ALU_SUB): sc_result = a - b;
      CTRL_W'(ALU_SLT): sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_W'(ALU_SRA): sc_result = $signed(a) >>> shamt;
      CTRL_W'(ALU_NOR): sc_result = ~(a | b);
      CTRL_W'(ALU_MUL): is_mul    = 1'b1;
`ifdef ALU_DIV_EN
      CTRL_W'(ALU_DIV): begin
        // Divide-by-zero resolves immediately instead of entering the divider.
        if (b == '0) begin
          sc_result  = '1;
          sc_illegal = 1'b1;
        end else begin
          is_div = 1'b1;
        end
      end
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  alu_iter_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_mul),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

`ifdef ALU_DIV_EN
  // Restoring divider on magnitudes: quotient bits shift into dvd_q.
  always_comb begin
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    div_neg_d = div_neg_q;
    div_cnt_d = div_cnt_q;
    rem_sh    = {rem_q, dvd_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, dvs_q};
    div_quot  = div_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    if (state_q == S_IDLE && accept && is_div) begin
      dvd_d     = a[WIDTH-1] ? (~a + 1'b1) : a;
      dvs_d     = b[WIDTH-1] ? (~b + 1'b1) : b;
      rem_d     = '0;
      div_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
      div_cnt_d = (SHAMT_W+1)'(WIDTH);
    end else if (state_q == S_DIV && div_cnt_q != '0) begin
      if (!rem_diff[WIDTH]) begin
        rem_d = rem_diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      end
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  // Divider working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      div_neg_q <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      div_neg_q <= div_neg_d;
      div_cnt_q <= div_cnt_d;
    end
  end
`endif

  // Next-state logic: multi-cycle ops park the FSM until their engine finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d = S_MUL;
        end
`ifdef ALU_DIV_EN
        else if (accept && is_div) begin
          state_d = S_DIV;
        end
`endif
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        if (div_cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output register updates: pop clears valid, results only change on
  // accept or engine completion, so a held result stays stable.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            out_valid_d = 1'b0;
          end
`ifdef ALU_DIV_EN
          else if (is_div) begin
            out_valid_d = 1'b0;
          end
`endif
          else begin
            result_d    = sc_result;
            zero_d      = (sc_result == '0);
            illegal_d   = sc_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        if (div_cnt_q == '0) begin
          result_d    = div_quot;
          zero_d      = (div_quot == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32); DIV cases follow ALU_DIV_EN.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_pipe #(
    .WIDTH  (32),
    .CTRL_W (4),
    .SHAMT_W(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero       (zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] res, input logic z, input logic ill);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.z = z; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Issue a multi-cycle op and measure accept-to-valid latency.
  task automatic do_iter(input string name, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] res, input logic z);
    int n;
    out_ready = 1'b1;
    a = va; b = vb; alu_control = op; in_valid = 1'b1;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd33);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_result"}, alu_result, res);
    chk({name, "_zero"}, 32'(zero), 32'(z));
    chk({name, "_illegal"}, 32'(illegal), 32'd0);
    tick();
    chk({name, "_popped"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit bad;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_control = '0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single-cycle vectors, issued back to back
    add_vec(4'b0010, 32'd5,         32'd3,         32'd8,         1'b0, 1'b0);
    add_vec(4'b0110, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1'b0);
    add_vec(4'b0111, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0);
    add_vec(4'b1100, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0, 1'b0);
    add_vec(4'b0000, 32'h0000F0F0,  32'h00000FF0,  32'h000000F0,  1'b0, 1'b0);
    add_vec(4'b0001, 32'h0000F0F0,  32'h00000FF0,  32'h0000FFF0,  1'b0, 1'b0);
    add_vec(4'b0011, 32'h0000F0F0,  32'h00000FF0,  32'h0000FF00,  1'b0, 1'b0);
    add_vec(4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0);
    add_vec(4'b0100, 32'd1,         32'h00000021,  32'd2,         1'b0, 1'b0);
    add_vec(4'b1001, 32'h80000000,  32'h00000024,  32'hF8000000,  1'b0, 1'b0);
    add_vec(4'b0101, 32'h80000000,  32'h00000024,  32'h08000000,  1'b0, 1'b0);
    add_vec(4'b0111, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b1, 1'b0);
    add_vec(4'b1001, 32'h7FFFFFF0,  32'd4,         32'h07FFFFFF,  1'b0, 1'b0);
    add_vec(4'b0110, 32'h10,        32'h10,        32'd0,         1'b1, 1'b0);
    add_vec(4'b1111, 32'd5,         32'd6,         32'd0,         1'b1, 1'b1);
    add_vec(4'b0010, 32'd1,         32'd2,         32'd3,         1'b0, 1'b0);
    add_vec(4'b1011, 32'd9,         32'd9,         32'd0,         1'b1, 1'b1);
`ifdef ALU_DIV_EN
    add_vec(4'b1010, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b0, 1'b1);
`else
    add_vec(4'b1010, 32'd5,         32'd0,         32'd0,         1'b1, 1'b1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      a = vecs[i].a; b = vecs[i].b; alu_control = vecs[i].op; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), alu_result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
    end
    in_valid = 1'b0;
    tick();
    chk("table_pop", 32'(out_valid), 32'd0);

    // Multiply latency and low-product results
    do_iter("mul_7x9", 4'b1000, 32'd7, 32'd9, 32'd63, 1'b0);
    do_iter("mul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
    do_iter("mul_zero", 4'b1000, 32'h12345, 32'd0, 32'd0, 1'b1);
    do_iter("mul_neg", 4'b1000, 32'hFFFFFFFD, 32'h00010000, 32'hFFFD0000, 1'b0);

    // Backpressure: result held, new op ignored until out_ready rises
    out_ready = 1'b0;
    a = 32'd0; b = 32'd0; alu_control = 4'b0010; in_valid = 1'b1;
    tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_zero", 32'(zero), 32'd1);
    chk("bp_result", alu_result, 32'd0);
    a = 32'h0000F0F0; b = 32'h00000FF0; alu_control = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_ready_low%0d", i), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp_hold_result%0d", i), alu_result, 32'd0);
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    tick();
    chk("bp_xor_result", alu_result, 32'h0000FF00);
    chk("bp_xor_valid", 32'(out_valid), 32'd1);
    chk("bp_xor_zero", 32'(zero), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("bp_pop", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    a = 32'd20; b = 32'd22; alu_control = 4'b0010; in_valid = 1'b1;
    tick();
    chk("pre_mul_add", alu_result, 32'd42);
    a = 32'd7; b = 32'd9; alu_control = 4'b1000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_mul_ready", 32'(in_ready), 32'd0);
    chk("mid_mul_hold", alu_result, 32'd42);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", alu_result, 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b0;
    tick();
    a = 32'd1; b = 32'd1; alu_control = 4'b0010; in_valid = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_add", alu_result, 32'd2);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) bad = 1'b1;
    end
    chk("mul_discarded", 32'(bad), 32'd0);

`ifdef ALU_DIV_EN
    do_iter("div_neg7_2", 4'b1010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    do_iter("div_100_7", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0);
    do_iter("div_n100_n7", 4'b1010, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 1'b0);
    do_iter("div_minneg", 4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    do_iter("div_small", 4'b1010, 32'd3, 32'd5, 32'd0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor of the datapath's combinational ALU. Lives in the EX stage. Accepts one operation per transfer on a valid/ready input.
- Single-cycle ops produce a registered result one cycle after acceptance. MUL runs on an iterative shift-add engine over WIDTH cycles, so it can stall the pipeline through backpressure.
- Adds shifts, an illegal-op flag and output backpressure, none of which the earlier block had.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- CTRL_W, 4, width of alu_control.
- SHAMT_W, 5, shift-amount bits taken from b[SHAMT_W-1:0]; must equal clog2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, or shift amount in low bits.
- alu_control  in  CTRL_W  operation code.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer accepts result.
- alu_result  out  WIDTH  registered result.
- zero  out  1  registered, equals (alu_result == 0).
- illegal  out  1  registered; set when the op code is undefined.

Behaviour:
- Op codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, MUL 1000, SRA 1001, NOR 1100.
  - DIV 1010 exists only with the optional feature.
  - All other codes are illegal.
- Reset (async, takes effect immediately):
  - State goes to IDLE.
  - out_valid=0, alu_result=0, zero=1, illegal=0.
  - In-flight MUL is discarded.
  - in_ready=0 while reset is high.
- States: IDLE, MUL_BUSY, (DIV_BUSY).
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational, so a result can be popped and a new op accepted in the same cycle.
- Accept happens on in_valid && in_ready:
  - Single-cycle op: alu_result, zero and illegal are written at that edge, and out_valid=1 next cycle. Latency is 1.
  - MUL: latch a and b and clear the accumulator; go to MUL_BUSY with counter=WIDTH-1. out_valid is cleared on entry unless it was already cleared by a pop.
- MUL_BUSY:
  - Each cycle: if multiplier bit0 is set, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1 (logical).
  - On the cycle counter==0: write alu_result = low WIDTH bits of acc (two's complement low product, identical for signed and unsigned), set out_valid, return to IDLE.
  - MUL latency: WIDTH+1 cycles from accept to out_valid (33 for WIDTH=32).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare; result is 1 or 0, zero-extended.
  - SRA is an arithmetic shift; SRL/SLL are logical. Shift amount is b[SHAMT_W-1:0]; upper bits of b are ignored.
- Illegal op: alu_result=0, zero=1, illegal=1, out_valid=1. This is a normal 1-cycle transfer.
- Output hold: alu_result, zero and illegal stay stable while out_valid && !out_ready. A pop (out_valid && out_ready) without a new accept clears out_valid.
- in_valid while not ready: inputs are ignored. The producer must hold them.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - Op 1010 = signed DIV, quotient truncated toward zero.
  - Implemented as restoring division on |a| and |b| in DIV_BUSY: WIDTH iterations, then a sign fix. Latency is WIDTH+1, same as MUL.
  - b==0: alu_result = all ones, illegal=1.
  - Most-negative / -1: alu_result = most-negative (wraps), illegal=0.
- Undefined: 1010 is illegal, DIV_BUSY does not exist, and the divider logic is absent.

Decomposition:
- Package alu_pkg holds:
  - Op-code localparams (ALU_AND ... ALU_NOR, ALU_DIV).
  - State enum values (S_IDLE, S_MUL, S_DIV).
- One sub-module, alu_iter_mul (WIDTH): start/operands in, done/product out.
  - The FSM in alu_pipe sequences it.
  - The divider, when enabled, sits inline in alu_pipe.

Test Plan:
- Reset mid-MUL: accept MUL 7*9, assert reset at cycle 5 -> out_valid=0, alu_result=0, zero=1 immediately. After release, ADD 1+1 -> alu_result=2 one cycle after accept.
- Back-to-back singles, out_ready=1: ADD 5+3, SUB 3-5, SLT -1<1, NOR 0|0 on consecutive cycles:
  - Results 8, 0xFFFFFFFE, 1, 0xFFFFFFFF.
  - One result per cycle, in_ready held at 1.
- MUL latency and sign: -3 * 0x00010000 -> in_ready=0 for 33 cycles, then alu_result=0xFFFD0000, zero=0.
- Backpressure: out_ready=0 after ADD 0+0 -> zero=1, result held, in_ready=0 for 4 cycles. Raise out_ready while in_valid with XOR 0xF0F0^0x0FF0 -> accepted the same cycle, next result 0xFF00.
- Shifts and illegal:
  - SRA 0x80000000 by b=0x24 (amount 4) -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - Op 1111 -> illegal=1, alu_result=0.
- ALU_DIV_EN:
  - -7/2 -> 0xFFFFFFFD after 33 cycles.
  - 5/0 -> 0xFFFFFFFF, illegal=1.
  - Without the macro, 1010 -> illegal=1 in 1 cycle.
